// File: rtl/rx_header_fields_bluetooth_ble.sv
`default_nettype none
// ============================================================================
// Module   : rx_header_fields_bluetooth_ble
// Purpose  : Serial receive-header field extractor. It collects HDR_BITS
//            de-HEC'd header bits LSB-first and waits for the HEC verdict.
//            It then reports the decoded fields, the HEC status and a
//            duplicate-SEQN flag. Short headers and missing HEC results are
//            reported as aborts. A saturating error counter is kept.
// Ports    : clk, reset (sync, active-high)
//            valid_in/data_bit   - serial header bit stream
//            hec_done/hec_error  - HEC check result pulse
//            clear_seq           - forget SEQN history (new connection)
//            hdr_valid/hdr_abort - one-cycle result pulses
//            lt_addr, pkt_type, flow, arqn, seqn, hec_ok, duplicate
//                                - decoded fields, held until next report
//            err_count           - saturating HEC-fail + abort count
//            busy                - FSM not idle
// Revision : 1.0 - initial release
// ============================================================================
module rx_header_fields_bluetooth_ble #(
  parameter int HDR_BITS = 10,
  parameter int TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  logic       data_bit,
  input  logic       hec_done,
  input  logic       hec_error,
  input  logic       clear_seq,
  output logic       hdr_valid,
  output logic       hdr_abort,
  output logic [2:0] lt_addr,
  output logic [3:0] pkt_type,
  output logic       flow,
  output logic       arqn,
  output logic       seqn,
  output logic       hec_ok,
  output logic       duplicate,
  output logic [7:0] err_count,
  output logic       busy
);

  localparam int c_cnt_w = (HDR_BITS > 2) ? $clog2(HDR_BITS) : 1;
  localparam int c_tmo_w = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(HDR_BITS - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COLLECT  = 2'd1,
    S_WAIT_HEC = 2'd2,
    S_REPORT   = 2'd3
  } state_t;

  state_t               state_q;
  logic [c_cnt_w-1:0]   bit_cnt_q;
  logic [c_tmo_w-1:0]   tmo_q;
  logic [HDR_BITS-1:0]  hdr_q;
  logic                 seq_seen_q;
  logic                 last_seqn_q;
  logic [7:0]           err_q;
  logic                 hdr_valid_q;
  logic                 hdr_abort_q;
  logic [2:0]           lt_addr_q;
  logic [3:0]           pkt_type_q;
  logic                 flow_q;
  logic                 arqn_q;
  logic                 seqn_q;
  logic                 hec_ok_q;
  logic                 dup_q;

  logic [7:0]           err_inc_d;
  logic                 dup_d;

  // Saturating increment: the counter sticks at 255 instead of wrapping.
  assign err_inc_d = (err_q == 8'hFF) ? err_q : (err_q + 8'd1);

  // Evaluated on the hec_done cycle against the history as it stood before
  // this header; a failed HEC can never be a duplicate.
  assign dup_d = ~hec_error & seq_seen_q & (hdr_q[9] == last_seqn_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      tmo_q       <= '0;
      hdr_q       <= '0;
      seq_seen_q  <= 1'b0;
      last_seqn_q <= 1'b0;
      err_q       <= 8'd0;
      hdr_valid_q <= 1'b0;
      hdr_abort_q <= 1'b0;
      lt_addr_q   <= 3'd0;
      pkt_type_q  <= 4'd0;
      flow_q      <= 1'b0;
      arqn_q      <= 1'b0;
      seqn_q      <= 1'b0;
      hec_ok_q    <= 1'b0;
      dup_q       <= 1'b0;
    end else begin
      // Result strobes are single-cycle unless re-asserted below.
      hdr_valid_q <= 1'b0;
      hdr_abort_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (valid_in) begin
            hdr_q[0]  <= data_bit;
            bit_cnt_q <= c_cnt_w'(1);
            state_q   <= S_COLLECT;
          end
        end

        S_COLLECT: begin
          if (valid_in) begin
            hdr_q[bit_cnt_q] <= data_bit;
            bit_cnt_q        <= bit_cnt_q + c_cnt_w'(1);
            if (bit_cnt_q == c_last_bit) begin
              tmo_q   <= '0;
              state_q <= S_WAIT_HEC;
            end
          end else begin
            // Gap in the bit stream before the header is complete.
            hdr_abort_q <= 1'b1;
            err_q       <= err_inc_d;
            state_q     <= S_IDLE;
          end
        end

        S_WAIT_HEC: begin
          // HEC/payload bits on valid_in/data_bit are deliberately not
          // captured here. hec_done outranks the timeout on the last count.
          if (hec_done) begin
            hec_ok_q    <= ~hec_error;
            dup_q       <= dup_d;
            lt_addr_q   <= hdr_q[2:0];
            pkt_type_q  <= hdr_q[6:3];
            flow_q      <= hdr_q[7];
            arqn_q      <= hdr_q[8];
            seqn_q      <= hdr_q[9];
            hdr_valid_q <= 1'b1;
            state_q     <= S_REPORT;
          end else if (tmo_q == c_tmo_last) begin
            hdr_abort_q <= 1'b1;
            err_q       <= err_inc_d;
            state_q     <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + c_tmo_w'(1);
          end
        end

        S_REPORT: begin
          // History only advances on a header whose HEC passed.
          if (hec_ok_q) begin
            last_seqn_q <= seqn_q;
            seq_seen_q  <= 1'b1;
          end else begin
            err_q <= err_inc_d;
          end
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase

      // Placed last so a clear on the same edge as a REPORT update wins.
      if (clear_seq) begin
        seq_seen_q <= 1'b0;
      end
    end
  end

  assign hdr_valid = hdr_valid_q;
  assign hdr_abort = hdr_abort_q;
  assign lt_addr   = lt_addr_q;
  assign pkt_type  = pkt_type_q;
  assign flow      = flow_q;
  assign arqn      = arqn_q;
  assign seqn      = seqn_q;
  assign hec_ok    = hec_ok_q;
  assign duplicate = dup_q;
  assign err_count = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rx_header_fields_bluetooth_ble.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_header_fields_bluetooth_ble
// Purpose  : Scoreboard bench for rx_header_fields_bluetooth_ble. The driver
//            issues headers (good, HEC fail, short, timeout) and pushes the
//            expected report or abort into a queue. A negedge monitor pops
//            and compares whenever a result pulse appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_header_fields_bluetooth_ble;

  localparam int HDR_BITS = 10;
  localparam int TIMEOUT  = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in, data_bit, hec_done, hec_error, clear_seq;
  logic       hdr_valid, hdr_abort;
  logic [2:0] lt_addr;
  logic [3:0] pkt_type;
  logic       flow, arqn, seqn, hec_ok, duplicate;
  logic [7:0] err_count;
  logic       busy;

  always #5 clk = ~clk;

  rx_header_fields_bluetooth_ble #(
    .HDR_BITS (HDR_BITS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_bit  (data_bit),
    .hec_done  (hec_done),
    .hec_error (hec_error),
    .clear_seq (clear_seq),
    .hdr_valid (hdr_valid),
    .hdr_abort (hdr_abort),
    .lt_addr   (lt_addr),
    .pkt_type  (pkt_type),
    .flow      (flow),
    .arqn      (arqn),
    .seqn      (seqn),
    .hec_ok    (hec_ok),
    .duplicate (duplicate),
    .err_count (err_count),
    .busy      (busy)
  );

  typedef struct {
    bit is_abort;
    int cyc;
    int lt;
    int pt;
    int fl;
    int aq;
    int sq;
    int ok;
    int dup;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  // Reference state: SEQN history and error total.
  bit   m_seen;
  int   m_last;
  int   m_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_seen = 0;
    m_last = 0;
    m_err  = 0;
  endtask

  task automatic model_report(input logic [9:0] bits, input bit err_in, input int cyc_exp);
    exp_t e;
    e.is_abort = 0;
    e.cyc = cyc_exp;
    e.lt = 0;
    e.pt = 0;
    for (int i = 0; i < 3; i++) if (bits[i]) e.lt += (1 << i);
    for (int i = 0; i < 4; i++) if (bits[3+i]) e.pt += (1 << i);
    e.fl  = bits[7] ? 1 : 0;
    e.aq  = bits[8] ? 1 : 0;
    e.sq  = bits[9] ? 1 : 0;
    e.ok  = err_in ? 0 : 1;
    e.dup = (e.ok == 1 && m_seen && e.sq == m_last) ? 1 : 0;
    if (e.ok == 1) begin
      m_last = e.sq;
      m_seen = 1;
    end else begin
      m_err = (m_err >= 255) ? 255 : m_err + 1;
    end
    e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic model_abort(input int cyc_exp);
    exp_t e;
    m_err = (m_err >= 255) ? 255 : m_err + 1;
    e = '{is_abort: 1, cyc: cyc_exp, lt: 0, pt: 0, fl: 0, aq: 0, sq: 0, ok: 0, dup: 0, err: m_err};
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  bit err_pend = 0;
  int err_exp  = 0;

  always @(negedge clk) begin
    exp_t e;
    // err_count is compared one cycle after each pulse, once every
    // increment belonging to that header has landed.
    if (err_pend) begin
      check("err_count_after_pulse", err_count, err_exp);
      err_pend = 0;
    end
    if (!reset && (hdr_valid === 1'b1 || hdr_abort === 1'b1)) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: hdr_valid=%b hdr_abort=%b, expected none at cycle %0d",
                 hdr_valid, hdr_abort, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("hdr_abort", hdr_abort, e.is_abort);
        check("hdr_valid", hdr_valid, !e.is_abort);
        if (e.is_abort) begin
          check("busy_at_abort", busy, 0);
        end else begin
          check("lt_addr", lt_addr, e.lt);
          check("pkt_type", pkt_type, e.pt);
          check("flow", flow, e.fl);
          check("arqn", arqn, e.aq);
          check("seqn", seqn, e.sq);
          check("hec_ok", hec_ok, e.ok);
          check("duplicate", duplicate, e.dup);
        end
        err_pend = 1;
        err_exp  = e.err;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in  = 1'b0;
    data_bit  = 1'b0;
    hec_done  = 1'b0;
    hec_error = 1'b0;
    clear_seq = 1'b0;
  endtask

  function automatic logic rbit();
    return ($urandom_range(0, 1) == 1);
  endfunction

  // Header bits, with stray hec_done pulses the block must ignore.
  task automatic put_bits(input logic [9:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      idle_inputs();
      valid_in = 1'b1;
      data_bit = bits[i];
      if ($urandom_range(0, 3) == 0) begin
        hec_done  = 1'b1;
        hec_error = rbit();
      end
    end
  endtask

  // hec_done arrives d cycles after the last header bit (1..TIMEOUT).
  task automatic hdr_good(input logic [9:0] bits, input int d, input bit err);
    put_bits(bits, HDR_BITS);
    for (int j = 1; j < d; j++) begin
      step();
      idle_inputs();
      valid_in = rbit();
      data_bit = rbit();
    end
    step();
    idle_inputs();
    valid_in  = rbit();
    data_bit  = rbit();
    hec_done  = 1'b1;
    hec_error = err;
    model_report(bits, err, cyc + 1);
    step();                 // REPORT cycle: valid_in must be ignored
    idle_inputs();
    valid_in = rbit();
    data_bit = rbit();
    step();
    idle_inputs();
  endtask

  task automatic hdr_timeout(input logic [9:0] bits);
    put_bits(bits, HDR_BITS);
    model_abort(cyc + 1 + TIMEOUT);
    for (int j = 1; j < TIMEOUT; j++) begin
      step();
      idle_inputs();
      valid_in = rbit();
      data_bit = rbit();
    end
    step();
    idle_inputs();
  endtask

  task automatic hdr_short(input logic [9:0] bits, input int k);
    put_bits(bits, k);
    step();
    idle_inputs();
    model_abort(cyc + 1);
  endtask

  task automatic gap(input int n, input bit clr);
    for (int i = 0; i < n; i++) begin
      step();
      idle_inputs();
      if (clr && i == 0) begin
        clear_seq = 1'b1;
        m_seen    = 0;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_hdr_valid"}, hdr_valid, 0);
    check({tag, "_hdr_abort"}, hdr_abort, 0);
    check({tag, "_fields"}, {lt_addr, pkt_type, flow, arqn, seqn}, 0);
    check({tag, "_hec_ok"}, hec_ok, 0);
    check({tag, "_duplicate"}, duplicate, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] g1;
    logic [9:0] g0;
    logic [9:0] rb;
    int         sel;
    // Arrival order 1,0,1,0,1,0,0,1,0,1 (bit 0 first).
    g1 = 10'b1010010101;
    g0 = 10'b0010010101;

    reset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    step();
    reset = 1'b0;
    gap(2, 0);

    // Reference header, then decoded values checked against fixed figures.
    hdr_good(g1, 1, 0);
    @(negedge clk);
    check("ref_fields", {lt_addr, pkt_type, flow, arqn, seqn}, {3'd5, 4'd2, 1'b1, 1'b0, 1'b1});
    check("ref_hec_dup", {hec_ok, duplicate}, 2'b10);
    check("ref_err_count", err_count, 0);
    gap(2, 0);
    hdr_good(g1, 2, 0);     // repeat -> duplicate
    gap(2, 0);
    hdr_good(g0, 3, 0);     // seqn 0 -> not duplicate
    gap(2, 1);              // clear history
    hdr_good(g0, 1, 0);     // not duplicate after clear
    gap(2, 0);
    hdr_good(g1, 2, 1);     // HEC fail, history unchanged
    gap(2, 0);
    hdr_good(g0, 1, 0);     // still matches last accepted seqn 0
    gap(2, 0);
    hdr_short(g1, 6);
    gap(2, 0);
    hdr_timeout(g1);
    gap(2, 0);
    hdr_good(g0, TIMEOUT, 0); // hec_done on the final count wins
    gap(2, 0);

    for (int n = 0; n < 120; n++) begin
      rb  = 10'($urandom_range(0, 1023));
      sel = $urandom_range(0, 19);
      if (sel < 11)      hdr_good(rb, (sel == 0) ? TIMEOUT : $urandom_range(1, 6), 1'b0);
      else if (sel < 14) hdr_good(rb, $urandom_range(1, 6), 1'b1);
      else if (sel < 18) hdr_short(rb, $urandom_range(1, HDR_BITS - 1));
      else               hdr_timeout(rb);
      gap($urandom_range(1, 3), ($urandom_range(0, 4) == 0));
    end

    // Reset in COLLECT and in WAIT_HEC: all outputs cleared, no pulses.
    gap(3, 0);
    put_bits(10'($urandom_range(0, 1023)), 5);
    step();
    idle_inputs();
    reset = 1'b1;
    model_reset();
    step();
    @(negedge clk);
    check_zero("reset_collect");
    step();
    reset = 1'b0;
    gap(3, 0);
    put_bits(g1, HDR_BITS);
    step();
    idle_inputs();
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    check_zero("reset_wait_hec");
    step();
    reset = 1'b0;
    gap(TIMEOUT + 4, 0);    // no late abort may appear

    // Saturation.
    for (int n = 0; n < 260; n++) begin
      hdr_good(10'($urandom_range(0, 1023)), 1, 1'b1);
    end
    gap(2, 0);
    check("err_saturated", err_count, 255);
    hdr_short(g0, 3);
    gap(3, 0);
    check("err_still_saturated", err_count, 255);

    gap(5, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_header_fields_bluetooth_ble.md
RX_HEADER_FIELDS_BLUETOOTH_BLE -- requirements
Module: rx_header_fields_bluetooth_ble

Interface
REQ-001 SHALL have parameter HDR_BITS, default 10, meaning header field bits preceding the HEC.
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of cycles spent in WAIT_HEC.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port valid_in, input, 1 bit: de-HEC data_out qualifier (de-HEC valid_out).
REQ-006 SHALL have port data_bit, input, 1 bit: serial header bit, sampled only when valid_in=1.
REQ-007 SHALL have port hec_done, input, 1 bit: one-cycle pulse marking a HEC check result.
REQ-008 SHALL have port hec_error, input, 1 bit: HEC remainder, where 1 means mismatch; sampled only with hec_done=1.
REQ-009 SHALL have port clear_seq, input, 1 bit: clears SEQN history (new connection).
REQ-010 SHALL have port hdr_valid, output, 1 bit: one-cycle pulse, header report.
REQ-011 SHALL have port hdr_abort, output, 1 bit: one-cycle pulse, short header or timeout.
REQ-012 SHALL have port lt_addr, output, 3 bits: logical transport address.
REQ-013 SHALL have port pkt_type, output, 4 bits: packet TYPE.
REQ-014 SHALL have outputs flow, arqn and seqn, each 1 bit: header flag bits.
REQ-015 SHALL have port hec_ok, output, 1 bit: 1 when the HEC passed.
REQ-016 SHALL have port duplicate, output, 1 bit: 1 when the SEQN repeats the last accepted SEQN.
REQ-017 SHALL have port err_count, output, 8 bits: saturating count of HEC failures plus aborts.
REQ-018 SHALL have port busy, output, 1 bit: 1 whenever the state is not IDLE.

Function
REQ-019 SHALL implement the four FSM states IDLE, COLLECT, WAIT_HEC and REPORT.
REQ-020 IDLE: on valid_in=1, the block SHALL store data_bit as bit 0, set bit_cnt=1 and go to COLLECT.
REQ-021 COLLECT: each valid_in=1 cycle SHALL store data_bit at index bit_cnt and increment bit_cnt.
  - When the stored bit is bit HDR_BITS-1, the next state is WAIT_HEC and the timeout counter clears to 0.
REQ-022 COLLECT: valid_in=0 before HDR_BITS bits are stored SHALL pulse hdr_abort, increment err_count and return to IDLE.
REQ-023 Bit mapping SHALL be LSB-first in arrival order:
  - bits 0-2 -> lt_addr[0..2]
  - bits 3-6 -> pkt_type[0..3]
  - bit 7 -> flow
  - bit 8 -> arqn
  - bit 9 -> seqn
REQ-024 WAIT_HEC SHALL ignore valid_in and data_bit; HEC and payload bits are not captured.
REQ-025 WAIT_HEC: hec_done=1 SHALL latch hec_ok = NOT hec_error and go to REPORT.
REQ-026 WAIT_HEC: if the timeout counter reaches TIMEOUT-1 without hec_done, the block SHALL pulse hdr_abort, increment err_count and return to IDLE.
  - hec_done on that same cycle takes priority, so the block goes to REPORT.
REQ-027 hec_done in IDLE, COLLECT or REPORT SHALL be ignored.
REQ-028 REPORT (one cycle) SHALL assert hdr_valid and update lt_addr, pkt_type, flow, arqn, seqn, hec_ok and duplicate together, then go to IDLE.
  - These outputs hold until the next REPORT.
REQ-029 duplicate SHALL equal hec_ok AND seq_seen AND (captured seqn == last_seqn).
REQ-030 In REPORT with hec_ok=1, the block SHALL set last_seqn to the captured seqn and set seq_seen=1; with hec_ok=0, both are unchanged.
REQ-031 In REPORT with hec_ok=0, err_count SHALL increment.
REQ-032 err_count SHALL saturate at 255 and never wrap.
REQ-033 clear_seq=1 SHALL clear seq_seen on the next edge in any state and SHALL NOT affect err_count or the FSM.
  - If REPORT would set seq_seen on that same edge, clear_seq wins.
REQ-034 Latency: hdr_valid SHALL assert exactly one cycle after the hec_done cycle.
REQ-035 Latency: hdr_abort SHALL assert one cycle after the detecting cycle.
REQ-036 A valid_in=1 in the REPORT cycle SHALL be ignored; a new header starts only from IDLE.

Reset
REQ-037 While reset=1 at a clock edge, the block SHALL go to IDLE and clear to 0:
  - bit_cnt, the timeout counter and err_count
  - seq_seen and last_seqn
  - hdr_valid, hdr_abort, lt_addr, pkt_type, flow, arqn, seqn, hec_ok, duplicate and busy
REQ-038 Reset asserted mid-header (any state) SHALL discard partial data and produce no hdr_valid or hdr_abort pulse.

Verification
REQ-039 Good header: bits 1,0,1, 0,1,0,0, 1, 0, 1, then hec_done with hec_error=0 -> one cycle later:
  - hdr_valid=1, lt_addr=5, pkt_type=2, flow=1, arqn=0, seqn=1
  - hec_ok=1, duplicate=0, err_count=0
REQ-040 Repeat the REQ-039 header -> duplicate=1. Then a header with seqn=0 -> duplicate=0. Then clear_seq followed by seqn=0 -> duplicate=0.
REQ-041 HEC fail: a header then hec_error=1 -> hec_ok=0, duplicate=0, err_count +1, and last_seqn unchanged.
REQ-042 Short header: 6 valid bits then valid_in=0 -> hdr_abort pulse, no hdr_valid, err_count +1, and busy=0 on the next cycle.
REQ-043 Timeout: 10 bits then no hec_done -> hdr_abort at cycle TIMEOUT after entering WAIT_HEC.
  - hec_done at count 63 instead -> hdr_valid, no abort.
REQ-044 Saturation and reset:
  - 260 HEC failures -> err_count=255.
  - reset asserted during COLLECT -> all outputs 0 and no pulses.
